fir_out_buffer: RTL and testbench
=================================

FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter DW, default 18, sample width in bits (two's complement).
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 4.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-005 Port i_valid  input  1  filter output-valid, sampled from the upstream FIR o_valid.
REQ-006 Port i_in  input  DW  filter output sample, sampled from the upstream FIR o_out.
REQ-007 Port o_clk_ena  output  1  clock enable driven to the upstream FIR clk_ena; low stalls the filter.
REQ-008 Port o_valid  output  1  head-of-FIFO sample available to the consumer.
REQ-009 Port o_data  output  DW  head-of-FIFO sample.
REQ-010 Port i_ready  input  1  consumer accepts o_data this cycle when o_valid is also high.
REQ-011 Port o_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012 Internal ena_q SHALL hold o_clk_ena as it was at the previous rising edge; it marks a cycle following an upstream advance.
REQ-013 Write condition w SHALL equal i_valid AND ena_q; a frozen upstream (ena_q==0) never causes a duplicate write of a held o_valid/o_out.
REQ-014 Read condition r SHALL equal o_valid AND i_ready.
REQ-015 When w==1, i_in SHALL be stored at wr_ptr at the next edge and wr_ptr SHALL advance modulo DEPTH.
REQ-016 When r==1, rd_ptr SHALL advance modulo DEPTH at the next edge.
REQ-017 o_count SHALL update as count + w - r; simultaneous w and r SHALL leave the count unchanged, including at count==DEPTH and count==0+pending.
REQ-018 o_clk_ena SHALL be combinational: 1 when (count + w) < DEPTH and reset==1, else 0; reads in the current cycle are not credited.
REQ-019 Given REQ-018, a write SHALL never occur at count==DEPTH; the design guarantees this by construction, with no overflow state.
REQ-020 The buffer is show-ahead: o_valid = (count != 0); o_data = mem[rd_ptr] when o_valid==1, else all zeros.
REQ-021 Latency: a sample written at edge k SHALL appear on o_data/o_valid in the cycle after edge k, with no write-to-read bypass when empty.
REQ-022 Data SHALL pass unmodified (no rounding, no sign change, full DW bits), in arrival order.
REQ-023 i_ready while o_valid==0 SHALL have no effect.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 without a bubble; sustained w=r=1 SHALL give one sample per cycle.

Reset
REQ-025 On an edge with reset==0: count, wr_ptr, rd_ptr, and ena_q SHALL become 0. Memory contents are not reset.
REQ-026 During reset==0, o_clk_ena SHALL be 0. After reset, o_valid==0, o_data==0, o_count==0.
REQ-027 Reset asserted mid-operation SHALL discard all stored samples. The first cycle after release SHALL have o_clk_ena==1 and ena_q==0, so no write occurs in that cycle.

Verification
REQ-028 Reset-then-release: hold reset=0 for 3 edges with i_valid=1 -> o_count=0, o_valid=0, o_data=0, and o_clk_ena=0 during reset; o_clk_ena=1 and no write in the first cycle after release.
REQ-029 Fill with stalled consumer: DEPTH=8, i_ready=0, i_valid=1 each cycle with i_in=1,2,3... -> o_clk_ena drops at the cycle where count+w reaches 8; o_count saturates at 8 and never exceeds it; o_data=1.
REQ-030 Frozen upstream hold: with the buffer full, i_valid held 1 and i_in held 9 for 5 cycles -> no write, count stays 8. Then assert i_ready for 1 cycle -> o_data=2 next, count 7; o_clk_ena returns 1; sample 9 is written exactly once.
REQ-031 Streaming: i_ready=1, i_valid=1 for 20 cycles with i_in=-5,-4,... -> outputs appear in order, each one cycle after its write; o_count stays at 1; pointers wrap twice with no gaps.
REQ-032 Simultaneous read/write when full: count=8, w=1 is impossible; force count=7 with w=1 and r=1 -> count remains 7 and o_clk_ena=1.
REQ-033 Mid-operation reset: reset=0 for one edge at count=5 -> next cycle o_count=0, o_valid=0; samples written afterwards start at o_data equal to the first new i_in.

Source files
------------

// File: rtl/fir_out_buffer.sv
// fir_out_buffer: show-ahead FIFO behind a FIR filter.
// Back-pressures the filter through its clock enable so no sample is lost.
module fir_out_buffer #(
    parameter int DW    = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [DW-1:0]            i_in,
    output logic                     o_clk_ena,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic              ena_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic              w;
    logic              r;
    logic [CW:0]       fill;

    // Handshake decode, enable generation and next-state computation.
    always_comb begin
        w         = i_valid & ena_q;
        o_valid   = (count_q != '0);
        r         = o_valid & i_ready;
        fill      = {1'b0, count_q} + {{CW{1'b0}}, w};
        o_clk_ena = reset & (fill < DEPTH_W);
        o_data    = o_valid ? mem_q[rd_ptr_q] : '0;
        o_count   = count_q;
        wr_ptr_d  = w ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = r ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({w, r})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the delayed enable that qualifies writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ena_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ena_q    <= o_clk_ena;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && w) begin
            mem_q[wr_ptr_q] <= i_in;
        end
    end

endmodule

// File: tb/tb_fir_out_buffer.sv
// tb_fir_out_buffer: scenario tasks checked against a queue-based model.
// The model tracks occupancy as a queue and the previous clock enable.
module tb_fir_out_buffer;

    localparam int DW    = 18;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [DW-1:0] i_in;
    logic          o_clk_ena;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    bit            m_ena;
    bit            mw;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          ee;
    logic [DW-1:0] up;

    fir_out_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_in      (i_in),
        .o_clk_ena (o_clk_ena),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current inputs, from the queue model.
    task automatic settle();
        #1;
        mw = i_valid && m_ena;
        ev = (q.size() != 0);
        ed = ev ? q[0] : '0;
        ec = CW'(q.size());
        ee = reset && ((q.size() + int'(mw)) < DEPTH);
    endtask

    // Advance the model across one rising edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            q.delete();
            m_ena = 1'b0;
        end else begin
            if (ev && i_ready) void'(q.pop_front());
            if (mw) q.push_back(i_in);
            m_ena = ee;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_in    = DW'($urandom);
        tick();
        for (int k = 0; k < 3; k++) begin
            i_in = DW'($urandom);
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {1'b0, {DW{1'b0}}, {CW{1'b0}}, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: v=%0b d=%0h c=%0d e=%0b exp 0/0/0/0",
                         o_valid, o_data, o_count, o_clk_ena);
            end
            tick();
        end
        reset = 1'b1;
        settle();
        n_checks++;
        if (o_clk_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ena: got %0b exp 1", o_clk_ena);
        end
        tick();
        settle();
        n_checks++;
        if (o_count !== '0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_nowrite: c=%0d v=%0b exp 0/0", o_count, o_valid);
        end
    endtask

    task automatic test_fill();
        i_ready = 1'b0;
        i_valid = 1'b1;
        up      = DW'(1);
        for (int k = 0; k < 14; k++) begin
            i_in = up;
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee}) begin
                n_fail++;
                $display("FAIL fill c%0d: v=%0b d=%0h c=%0d e=%0b exp v=%0b d=%0h c=%0d e=%0b",
                         k, o_valid, o_data, o_count, o_clk_ena, ev, ed, ec, ee);
            end
            n_checks++;
            if (o_count > CW'(DEPTH)) begin
                n_fail++;
                $display("FAIL fill_sat: count %0d exp <= %0d", o_count, DEPTH);
            end
            tick();
            if (mw) up = up + DW'(1);
        end
        settle();
        n_checks++;
        if (o_data !== DW'(1) || o_count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_end: d=%0h c=%0d exp 1/%0d", o_data, o_count, DEPTH);
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] got[$];
        int            n9;
        i_valid = 1'b1;
        i_in    = DW'(9);
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee} || o_count !== CW'(8)) begin
                n_fail++;
                $display("FAIL hold c%0d: d=%0h c=%0d e=%0b exp d=%0h c=8 e=%0b",
                         k, o_data, o_count, o_clk_ena, ed, ee);
            end
            tick();
        end
        i_ready = 1'b1;
        settle();
        tick();
        i_ready = 1'b0;
        settle();
        n_checks++;
        if (o_data !== DW'(2) || o_count !== CW'(7) || o_clk_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_read: d=%0h c=%0d e=%0b exp 2/7/1", o_data, o_count, o_clk_ena);
        end
        for (int k = 0; k < 4; k++) begin
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee}) begin
                n_fail++;
                $display("FAIL hold_refill c%0d: c=%0d e=%0b exp c=%0d e=%0b",
                         k, o_count, o_clk_ena, ec, ee);
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee}) begin
                n_fail++;
                $display("FAIL drain c%0d: v=%0b d=%0h c=%0d exp v=%0b d=%0h c=%0d",
                         k, o_valid, o_data, o_count, ev, ed, ec);
            end
            if (o_valid) got.push_back(o_data);
            tick();
        end
        n9 = 0;
        foreach (got[k]) if (got[k] == DW'(9)) n9++;
        n_checks++;
        if (n9 != 1 || got.size() != 8) begin
            n_fail++;
            $display("FAIL hold_once: nines=%0d popped=%0d exp 1/8", n9, got.size());
        end
        foreach (got[k]) begin
            n_checks++;
            if (got[k] !== DW'(k + 2)) begin
                n_fail++;
                $display("FAIL drain_order %0d: got %0h exp %0h", k, got[k], k + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] nxt;
        reset   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        settle();
        tick();
        reset = 1'b1;
        up    = DW'(-5);
        nxt   = DW'(-5);
        for (int k = 0; k < 22; k++) begin
            i_in = up;
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee} || o_count > CW'(1)) begin
                n_fail++;
                $display("FAIL stream c%0d: v=%0b d=%0h c=%0d e=%0b exp v=%0b d=%0h c=%0d e=%0b",
                         k, o_valid, o_data, o_count, o_clk_ena, ev, ed, ec, ee);
            end
            if (k >= 2) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== nxt) begin
                    n_fail++;
                    $display("FAIL stream_seq c%0d: v=%0b d=%0h exp 1/%0h", k, o_valid, o_data, nxt);
                end
                nxt = nxt + DW'(1);
            end
            tick();
            if (mw) up = up + DW'(1);
        end
    endtask

    task automatic test_simul();
        reset   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 20 && q.size() < 7; k++) begin
            i_in = DW'($urandom);
            settle();
            tick();
        end
        i_ready = 1'b1;
        i_in    = DW'($urandom);
        settle();
        n_checks++;
        if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee}) begin
            n_fail++;
            $display("FAIL simul: d=%0h c=%0d e=%0b exp d=%0h c=%0d e=%0b",
                     o_data, o_count, o_clk_ena, ed, ec, ee);
        end
        tick();
        i_ready = 1'b0;
        i_valid = 1'b0;
        settle();
        n_checks++;
        if (o_count !== CW'(7) || o_clk_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_after: c=%0d e=%0b exp 7/1", o_count, o_clk_ena);
        end
    endtask

    task automatic test_midreset();
        logic [DW-1:0] first;
        reset   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 20 && q.size() < 5; k++) begin
            i_in = DW'($urandom);
            settle();
            tick();
        end
        reset = 1'b0;
        settle();
        n_checks++;
        if (o_count !== CW'(5) || o_clk_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_pre: c=%0d e=%0b exp 5/0", o_count, o_clk_ena);
        end
        tick();
        reset = 1'b1;
        first = DW'($urandom);
        i_in  = first;
        settle();
        n_checks++;
        if (o_count !== '0 || o_valid !== 1'b0 || o_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_clr: c=%0d v=%0b d=%0h exp 0/0/0", o_count, o_valid, o_data);
        end
        tick();
        settle();
        tick();
        settle();
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== first) begin
            n_fail++;
            $display("FAIL midreset_first: v=%0b d=%0h exp 1/%0h", o_valid, o_data, first);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset   = ($urandom_range(0, 49) != 0);
            i_valid = 1'($urandom);
            i_ready = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
            i_in    = DW'($urandom);
            settle();
            n_checks++;
            if ({o_valid, o_data, o_count, o_clk_ena} !== {ev, ed, ec, ee}) begin
                n_fail++;
                $display("FAIL random c%0d: v=%0b d=%0h c=%0d e=%0b exp v=%0b d=%0h c=%0d e=%0b",
                         k, o_valid, o_data, o_count, o_clk_ena, ev, ed, ec, ee);
            end
            tick();
        end
    endtask

    initial begin
        reset   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_in    = '0;
        m_ena   = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hold();
        test_back_to_back();
        test_simul();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
